miner_nonce_sequencer: RTL and testbench
========================================

Name: miner_nonce_sequencer

Overview:
- Feeds the SHA-256 transform pipeline and consumes its final hash.
- Accepts a mining job: midstate, 96-bit block tail, and a nonce range.
- Generates the transform controls feedback, cnt, rx_state and rx_input, stepping one nonce per LOOP cycles.
- Matches each returned second-pass hash word to the nonce that produced it and reports golden nonces through a valid/ready handshake.

Parameters:
- LOOP, 4: cycles per hash slot; one of 1,2,4,8,16,32,64; must equal the transform LOOP.
- NONCE_LAT, 136: cycles from a slot presenting nonce N on rx_input to hash_in carrying H7 of sha256(sha256(block(N))); must be a multiple of LOOP, ≥ LOOP.
- DEPTH (localparam), NONCE_LAT/LOOP: nonces in flight.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- job_valid  in  1  job offered
- job_ready  out  1  high exactly when state==IDLE
- job_midstate  in  256  initial state for first transform
- job_data  in  96  block words 0..2
- job_nonce_first  in  32  first nonce
- job_nonce_last  in  32  last nonce, inclusive
- job_abort  in  1  cancel current job
- feedback  out  1  transform feedback select
- cnt  out  6  transform round-group index
- rx_state  out  256  registered job_midstate
- rx_input  out  512  block for first transform
- hash_in  in  32  tx_hash[255:224] of second transform
- golden_valid  out  1  golden nonce held
- golden_ready  in  1  consumer accepts
- golden_nonce  out  32  nonce whose H7==0
- golden_overflow  out  1  sticky: a golden nonce was dropped
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at normal job completion

Behaviour:
- Reset values: job_ready=1 from the first cycle after reset.
  - All outputs 0: feedback, cnt, rx_state, rx_input, golden_valid, golden_nonce, golden_overflow, busy, done.
  - state=IDLE.
- rx_input word layout (word w = bits [32w+31:32w]):
  - words 0..2 = job_data[95:0]
  - word 3 = current nonce
  - word 4 = 32'h80000000
  - words 5..14 = 0
  - word 15 = 32'h00000280
- States:
  - IDLE: cnt=0, feedback=0.
  - Acceptance: job_valid && job_ready at edge T registers all job fields and clears golden_overflow. At T+1, state=RUN, cnt=0, nonce=job_nonce_first.
  - RUN/DRAIN: cnt counts 0..LOOP-1 and wraps; feedback = (cnt != 0), so it is constantly 0 when LOOP=1.
  - Slot: each cycle with cnt==0 in RUN or DRAIN. Slot k (k from 0) presents nonce first+k in RUN.
  - Nonce stepping: increments (mod 2^32) on the edge where cnt==LOOP-1, except on the slot carrying job_nonce_last.
  - Range: slots issued = (last-first) mod 2^32 + 1, so a range with last < first wraps through 0xFFFFFFFF.
  - RUN→DRAIN: on the edge ending the last issued slot. DRAIN holds rx_input unchanged and runs exactly DEPTH further slots.
  - Completion: after the final DRAIN slot, go to IDLE and pulse done for one cycle.
- Checking:
  - On slot k ≥ DEPTH, sample hash_in. It belongs to nonce first+k-DEPTH, computed as current slot nonce − DEPTH (mod 2^32); in DRAIN, use a shadow counter that keeps counting.
  - Golden condition: hash_in == 32'h0. Slots k < DEPTH are never checked.
- Golden handshake:
  - Transfer occurs when golden_valid && golden_ready.
  - A find with the register empty, or emptied in the same cycle by a transfer, loads golden_nonce and sets/keeps golden_valid=1.
  - A find while golden_valid && !golden_ready drops the new nonce and sets golden_overflow. The held nonce is unchanged.
  - golden_nonce is stable while golden_valid && !golden_ready.
- job_abort:
  - In RUN/DRAIN, next state is IDLE, with no done pulse and pending checks discarded.
  - The golden register and overflow are retained. Ignored in IDLE.
  - Abort has priority over the RUN→DRAIN and DRAIN→IDLE transitions in the same cycle.
- Reset mid-job: returns to the full reset values next cycle, including clearing golden_valid.
- job_valid outside IDLE is ignored (job_ready=0).

Test Plan:
- Bench settings: LOOP=4, NONCE_LAT=8 (DEPTH=2); hash_in driven by a delay-line model returning 0 for chosen nonces, else 32'hFFFFFFFF.
- Reset then job first=0x10, last=0x13 → rx_input word3 steps 0x10..0x13 every 4 cycles, cnt 0,1,2,3 repeats, feedback low only at cnt=0. Exactly 6 slots run, done pulses once, then job_ready=1; word4=0x80000000, word15=0x00000280.
- Golden on 0x11 with golden_ready=1 → golden_valid=1 with golden_nonce=0x11 at slot k=3; no overflow.
- Goldens on 0x11 and 0x12 with golden_ready=0 → golden_nonce stays 0x11 and golden_overflow=1. A new job clears overflow only.
- Wrap job first=0xFFFFFFFE, last=0x00000001 → 4 nonces issued (…FE, …FF, 0, 1). Golden on 0x0 reported as 0x00000000.
- job_abort asserted mid-RUN at slot 1 → IDLE next cycle with no done, and no golden reported for in-flight nonces.
- LOOP=1, NONCE_LAT=3, first=last=0x5 → feedback always 0, 1 RUN slot plus 3 DRAIN slots, then done.
- reset asserted in DRAIN with golden_valid=1 → all outputs back to reset values the next cycle.

Source files
------------

// File: rtl/miner_nonce_sequencer_if.sv
// miner_nonce_sequencer_if: job intake, transform control/feedback and golden-nonce handshake bundle
interface miner_nonce_sequencer_if;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_midstate;
    logic [95:0]  job_data;
    logic [31:0]  job_nonce_first;
    logic [31:0]  job_nonce_last;
    logic         job_abort;
    logic         feedback;
    logic [5:0]   cnt;
    logic [255:0] rx_state;
    logic [511:0] rx_input;
    logic [31:0]  hash_in;
    logic         golden_valid;
    logic         golden_ready;
    logic [31:0]  golden_nonce;
    logic         golden_overflow;
    logic         busy;
    logic         done;
    modport master (
        output job_valid, job_midstate, job_data, job_nonce_first, job_nonce_last, job_abort,
               hash_in, golden_ready,
        input  job_ready, feedback, cnt, rx_state, rx_input, golden_valid, golden_nonce,
               golden_overflow, busy, done
    );
    modport slave (
        input  job_valid, job_midstate, job_data, job_nonce_first, job_nonce_last, job_abort,
               hash_in, golden_ready,
        output job_ready, feedback, cnt, rx_state, rx_input, golden_valid, golden_nonce,
               golden_overflow, busy, done
    );
endinterface

// File: rtl/miner_nonce_sequencer.sv
// miner_nonce_sequencer: steps nonces into the SHA-256 transform and matches returned H7 words to golden nonces
module miner_nonce_sequencer #(
    parameter int LOOP      = 4,
    parameter int NONCE_LAT = 136
) (
    input logic clk,
    input logic reset,
    miner_nonce_sequencer_if.slave bus
);
    localparam int DEPTH = NONCE_LAT / LOOP;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [255:0] mid_q, mid_d;
    logic [95:0]  data_q, data_d;
    logic [31:0]  nonce_q, nonce_d, last_q, last_d, shadow_q, shadow_d;
    logic [31:0]  seen_q, seen_d, drain_q, drain_d, gnonce_q, gnonce_d;
    logic         loaded_q, loaded_d, gvalid_q, gvalid_d, ovf_q, ovf_d, done_q, done_d;
    logic         active, accept, slot, slot_end, xfer, find;
    // shadow_q tracks the slot nonce even in DRAIN, where rx_input is frozen
    always_comb begin
        active   = state_q != IDLE;
        accept   = state_q == IDLE && bus.job_valid;
        slot     = active && cnt_q == 6'd0;
        slot_end = active && cnt_q == 6'(LOOP - 1);
        xfer     = gvalid_q && bus.golden_ready;
        find     = slot && !bus.job_abort && seen_q == 32'(DEPTH) && bus.hash_in == 32'h0;
        state_d  = state_q;
        cnt_d    = active ? (slot_end ? 6'd0 : cnt_q + 6'd1) : 6'd0;
        mid_d    = mid_q;
        data_d   = data_q;
        nonce_d  = nonce_q;
        last_d   = last_q;
        shadow_d = slot_end ? shadow_q + 32'd1 : shadow_q;
        seen_d   = (slot && seen_q != 32'(DEPTH)) ? seen_q + 32'd1 : seen_q;
        drain_d  = (slot_end && state_q == DRAIN) ? drain_q + 32'd1 : drain_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        gvalid_d = find ? 1'b1 : (xfer ? 1'b0 : gvalid_q);
        gnonce_d = (find && (!gvalid_q || xfer)) ? shadow_q - 32'(DEPTH) : gnonce_q;
        ovf_d    = ovf_q | (find && gvalid_q && !bus.golden_ready);
        if (accept) begin
            state_d  = RUN;
            mid_d    = bus.job_midstate;
            data_d   = bus.job_data;
            nonce_d  = bus.job_nonce_first;
            last_d   = bus.job_nonce_last;
            shadow_d = bus.job_nonce_first;
            seen_d   = 32'd0;
            drain_d  = 32'd0;
            loaded_d = 1'b1;
            ovf_d    = 1'b0;
        end else if (active && bus.job_abort) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
        end else if (slot_end && state_q == RUN) begin
            if (nonce_q == last_q) state_d = DRAIN;
            else nonce_d = nonce_q + 32'd1;
        end else if (slot_end && state_q == DRAIN && drain_q == 32'(DEPTH - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mid_q    <= '0;
            data_q   <= '0;
            nonce_q  <= '0;
            last_q   <= '0;
            shadow_q <= '0;
            seen_q   <= '0;
            drain_q  <= '0;
            gnonce_q <= '0;
            loaded_q <= 1'b0;
            gvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mid_q    <= mid_d;
            data_q   <= data_d;
            nonce_q  <= nonce_d;
            last_q   <= last_d;
            shadow_q <= shadow_d;
            seen_q   <= seen_d;
            drain_q  <= drain_d;
            gnonce_q <= gnonce_d;
            loaded_q <= loaded_d;
            gvalid_q <= gvalid_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end
    assign bus.job_ready       = state_q == IDLE;
    assign bus.busy            = state_q != IDLE;
    assign bus.cnt             = cnt_q;
    assign bus.feedback        = cnt_q != 6'd0;
    assign bus.rx_state        = mid_q;
    assign bus.rx_input        = {loaded_q ? 32'h0000_0280 : 32'h0, 320'h0,
                                  loaded_q ? 32'h8000_0000 : 32'h0, nonce_q, data_q};
    assign bus.golden_valid    = gvalid_q;
    assign bus.golden_nonce    = gnonce_q;
    assign bus.golden_overflow = ovf_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_miner_nonce_sequencer.sv
// tb_miner_nonce_sequencer: directed jobs on a LOOP=4 and a LOOP=1 instance, golden nonces tracked by a scoreboard
module tb_miner_nonce_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] dl4 [8];
    logic [31:0] ga, gb;
    logic ea = 1'b0, eb = 1'b0;
    logic [255:0] mid = {8{32'hDEAD_BEEF}};
    logic [95:0] dat = 96'h0123_4567_89AB_CDEF_0011_2233;
    logic [31:0] wexp [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h1};
    logic sawd, sawg;
    always #5 clk = ~clk;
    miner_nonce_sequencer_if b4();
    miner_nonce_sequencer_if b1();
    miner_nonce_sequencer #(.LOOP(4), .NONCE_LAT(8)) u4 (.clk(clk), .reset(reset), .bus(b4));
    miner_nonce_sequencer #(.LOOP(1), .NONCE_LAT(3)) u1 (.clk(clk), .reset(reset), .bus(b1));
    // transform pipeline stand-in: nonce presented 8 cycles ago comes back as H7
    always @(posedge clk) begin
        dl4[0] <= b4.rx_input[127:96];
        for (int i = 1; i < 8; i++) dl4[i] <= dl4[i-1];
    end
    assign b4.hash_in = ((ea && dl4[7] === ga) || (eb && dl4[7] === gb)) ? 32'h0 : 32'hFFFF_FFFF;
    assign b1.hash_in = 32'hFFFF_FFFF;
    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        #1;
        if (b4.golden_valid && b4.golden_ready) begin
            chk("gold_pop_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("gold_nonce_sb", b4.golden_nonce, exp_q.pop_front());
        end
    end
    task automatic start4(input logic [31:0] first, input logic [31:0] last);
        b4.job_nonce_first = first;
        b4.job_nonce_last  = last;
        b4.job_valid = 1'b1;
        @(negedge clk);
        b4.job_valid = 1'b0;
    endtask
    task automatic wait_done(input int budget);
        int n = 0;
        while (b4.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", b4.done, 1'b1);
    endtask
    task automatic chk_reset();
        chk("rst_job_ready", b4.job_ready, 1'b1);
        chk("rst_busy", b4.busy, 1'b0);
        chk("rst_cnt", b4.cnt, 6'd0);
        chk("rst_feedback", b4.feedback, 1'b0);
        chk("rst_rx_state", b4.rx_state, 256'h0);
        chk("rst_rx_input", b4.rx_input, 512'h0);
        chk("rst_gvalid", b4.golden_valid, 1'b0);
        chk("rst_gnonce", b4.golden_nonce, 32'h0);
        chk("rst_ovf", b4.golden_overflow, 1'b0);
        chk("rst_done", b4.done, 1'b0);
    endtask
    initial begin
        b4.job_valid = 1'b0; b4.job_abort = 1'b0; b4.golden_ready = 1'b1;
        b4.job_midstate = mid; b4.job_data = dat; b4.job_nonce_first = '0; b4.job_nonce_last = '0;
        b1.job_valid = 1'b0; b1.job_abort = 1'b0; b1.golden_ready = 1'b1;
        b1.job_midstate = mid; b1.job_data = dat; b1.job_nonce_first = '0; b1.job_nonce_last = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset();
        // plain sweep 0x10..0x13: 4 RUN slots + 2 DRAIN slots
        start4(32'h10, 32'h13);
        chk("rx_state", b4.rx_state, mid);
        chk("words0_2", b4.rx_input[95:0], dat);
        chk("word4", b4.rx_input[159:128], 32'h8000_0000);
        chk("words5_14", b4.rx_input[479:160], 320'h0);
        chk("word15", b4.rx_input[511:480], 32'h0000_0280);
        for (int i = 0; i < 24; i++) begin
            chk("cnt", b4.cnt, 6'(i % 4));
            chk("feedback", b4.feedback, (i % 4) != 0);
            chk("word3", b4.rx_input[127:96], 32'h10 + 32'((i / 4 > 3) ? 3 : i / 4));
            chk("busy_done", {b4.busy, b4.done}, 2'b10);
            @(negedge clk);
        end
        chk("done_pulse", {b4.done, b4.job_ready, b4.busy}, 3'b110);
        @(negedge clk);
        chk("done_once", b4.done, 1'b0);
        // single golden with consumer ready
        ga = 32'h11; ea = 1'b1;
        exp_q.push_back(32'h11);
        start4(32'h10, 32'h13);
        repeat (13) @(negedge clk);
        chk("g1_valid", b4.golden_valid, 1'b1);
        chk("g1_nonce", b4.golden_nonce, 32'h11);
        chk("g1_ovf", b4.golden_overflow, 1'b0);
        wait_done(20);
        chk("g1_ovf_end", b4.golden_overflow, 1'b0);
        // two goldens with consumer stalled: second is dropped
        b4.golden_ready = 1'b0;
        gb = 32'h12; eb = 1'b1;
        exp_q.push_back(32'h11);
        @(negedge clk);
        start4(32'h10, 32'h13);
        repeat (13) @(negedge clk);
        chk("g2_valid", b4.golden_valid, 1'b1);
        chk("g2_nonce", b4.golden_nonce, 32'h11);
        wait_done(20);
        chk("g2_hold_nonce", b4.golden_nonce, 32'h11);
        chk("g2_ovf", b4.golden_overflow, 1'b1);
        ea = 1'b0; eb = 1'b0;
        start4(32'h20, 32'h20);
        chk("newjob_ovf_clr", b4.golden_overflow, 1'b0);
        chk("newjob_gvalid", b4.golden_valid, 1'b1);
        chk("newjob_gnonce", b4.golden_nonce, 32'h11);
        b4.golden_ready = 1'b1;
        wait_done(20);
        // range wrapping through 0xFFFFFFFF with a golden on 0
        ga = 32'h0; ea = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        start4(32'hFFFF_FFFE, 32'h1);
        for (int s = 0; s < 5; s++) begin
            chk("wrap_word3", b4.rx_input[127:96], wexp[s]);
            repeat (4) @(negedge clk);
        end
        wait_done(10);
        ea = 1'b0;
        // abort in RUN at slot 1 with goldens in flight
        ga = 32'h30; gb = 32'h31; ea = 1'b1; eb = 1'b1;
        @(negedge clk);
        start4(32'h30, 32'h33);
        repeat (4) @(negedge clk);
        chk("abort_slot1", b4.rx_input[127:96], 32'h31);
        b4.job_abort = 1'b1;
        @(negedge clk);
        b4.job_abort = 1'b0;
        chk("abort_idle", {b4.busy, b4.job_ready, b4.done, b4.cnt}, {3'b010, 6'd0});
        sawd = 1'b0; sawg = 1'b0;
        repeat (30) begin
            @(negedge clk);
            sawd |= b4.done;
            sawg |= b4.golden_valid;
        end
        chk("abort_no_done", sawd, 1'b0);
        chk("abort_no_gold", sawg, 1'b0);
        ea = 1'b0; eb = 1'b0;
        // LOOP=1 instance: one RUN slot then DEPTH=3 DRAIN slots
        b1.job_nonce_first = 32'h5; b1.job_nonce_last = 32'h5; b1.job_valid = 1'b1;
        @(negedge clk);
        b1.job_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("l1_fb_busy_done", {b1.feedback, b1.busy, b1.done}, 3'b010);
            chk("l1_word3", b1.rx_input[127:96], 32'h5);
            @(negedge clk);
        end
        chk("l1_done", {b1.done, b1.busy, b1.job_ready}, 3'b101);
        chk("l1_no_gold", b1.golden_valid, 1'b0);
        // reset during DRAIN while a golden is held
        b4.golden_ready = 1'b0;
        ga = 32'h40; ea = 1'b1;
        @(negedge clk);
        start4(32'h40, 32'h41);
        repeat (10) @(negedge clk);
        chk("pre_rst_gvalid", {b4.golden_valid, b4.busy, b4.golden_nonce}, {2'b11, 32'h40});
        reset = 1'b1;
        @(negedge clk);
        chk_reset();
        reset = 1'b0;
        ea = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
